// File: rtl/flood_pkg.sv
// Shared constants and state encoding for the Flood-It game sequencer.
// Holds the board-size, colour-count and try-count limits plus the FSM state type.
package flood_pkg;

    localparam int SIZE_W  = 5;
    localparam int COLOR_W = 4;
    localparam int TRY_W   = 8;

    localparam int FLOOD_SIZE_MIN      = 2;
    localparam int FLOOD_SIZE_MAX      = 14;
    localparam int FLOOD_SIZE_DEFAULT  = 6;
    localparam int FLOOD_COLOR_MIN     = 3;
    localparam int FLOOD_COLOR_MAX     = 6;
    localparam int FLOOD_COLOR_DEFAULT = 4;
    localparam int FLOOD_TRY_CAP       = 99;

    localparam logic [2:0] ST_SET_SIZE  = 3'd0;
    localparam logic [2:0] ST_SET_COLOR = 3'd1;
    localparam logic [2:0] ST_PLAY      = 3'd2;
    localparam logic [2:0] ST_WON       = 3'd3;
    localparam logic [2:0] ST_LOST      = 3'd4;

    typedef enum logic [2:0] {
        SET_SIZE  = ST_SET_SIZE,
        SET_COLOR = ST_SET_COLOR,
        PLAY      = ST_PLAY,
        WON       = ST_WON,
        LOST      = ST_LOST
    } state_t;

endpackage

// File: rtl/flood_try_budget.sv
// Move budget for a new game: SIZE + (SIZE*COLOR_NUM)/2, clipped to the try cap.
// Purely combinational; the sequencer samples it on the start edge.
module flood_try_budget
    import flood_pkg::*;
#(
    parameter int TRY_CAP = FLOOD_TRY_CAP
) (
    input  logic [SIZE_W-1:0]  SIZE,
    input  logic [COLOR_W-1:0] COLOR_NUM,
    output logic [TRY_W-1:0]   TOTAL_TRIES
);

    logic [8:0] product;
    logic [8:0] sum;

    // Widest input pair (31 x 15) still fits 9 bits, and so does the sum.
    assign product     = {4'b0, SIZE} * {5'b0, COLOR_NUM};
    assign sum         = {4'b0, SIZE} + {1'b0, product[8:1]};
    assign TOTAL_TRIES = (sum > 9'(TRY_CAP)) ? TRY_W'(TRY_CAP) : sum[TRY_W-1:0];

endmodule

// File: rtl/flood_game_ctrl.sv
// Flood-It game sequencer: setup of board size / colour count, move counting
// against a budget, and win/lose reporting for the seven-segment display.
module flood_game_ctrl
    import flood_pkg::*;
#(
    parameter int SIZE_MIN      = FLOOD_SIZE_MIN,
    parameter int SIZE_MAX      = FLOOD_SIZE_MAX,
    parameter int SIZE_DEFAULT  = FLOOD_SIZE_DEFAULT,
    parameter int COLOR_MIN     = FLOOD_COLOR_MIN,
    parameter int COLOR_MAX     = FLOOD_COLOR_MAX,
    parameter int COLOR_DEFAULT = FLOOD_COLOR_DEFAULT,
    parameter int TRY_CAP       = FLOOD_TRY_CAP
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic               BTN_UP,
    input  logic               BTN_DOWN,
    input  logic               BTN_SEL,
    input  logic               BTN_START,
    input  logic               MOVE_VALID,
    input  logic               BOARD_DONE,
    output logic [SIZE_W-1:0]  SIZE,
    output logic [COLOR_W-1:0] COLOR_NUM,
    output logic               sORc,
    output logic               MODE,
    output logic [TRY_W-1:0]   TRIES,
    output logic [TRY_W-1:0]   TOTAL_TRIES,
    output logic               GAME_START,
    output logic               WIN,
    output logic               LOSE
);

    state_t             state_q, state_d;
    logic [SIZE_W-1:0]  size_d;
    logic [COLOR_W-1:0] color_d;
    logic               sorc_d, mode_d, game_start_d, win_d, lose_d;
    logic [TRY_W-1:0]   tries_d, total_d, tries_inc, budget;
    // Counts down the cycles after a start in which BOARD_DONE is still stale.
    logic [1:0]         hold_q, hold_d;
    logic               adjust;

    flood_try_budget #(.TRY_CAP(TRY_CAP)) u_budget (
        .SIZE        (SIZE),
        .COLOR_NUM   (COLOR_NUM),
        .TOTAL_TRIES (budget)
    );

    assign tries_inc = (TRIES < TRY_W'(TRY_CAP)) ? TRIES + 1'b1 : TRIES;
    assign adjust    = BTN_UP ^ BTN_DOWN;

    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d      = state_q;
        size_d       = SIZE;
        color_d      = COLOR_NUM;
        sorc_d       = sORc;
        mode_d       = MODE;
        tries_d      = TRIES;
        total_d      = TOTAL_TRIES;
        game_start_d = 1'b0;
        win_d        = WIN;
        lose_d       = LOSE;
        hold_d       = hold_q;

        case (state_q)
            SET_SIZE, SET_COLOR: begin
                if (BTN_START) begin
                    state_d      = PLAY;
                    mode_d       = 1'b1;
                    tries_d      = '0;
                    total_d      = budget;
                    game_start_d = 1'b1;
                    hold_d       = 2'd2;
                end else if (BTN_SEL) begin
                    state_d = (state_q == SET_SIZE) ? SET_COLOR : SET_SIZE;
                    sorc_d  = (state_q == SET_COLOR);
                end else if (adjust && state_q == SET_SIZE) begin
                    if (BTN_UP && SIZE < SIZE_W'(SIZE_MAX))
                        size_d = SIZE + 1'b1;
                    else if (BTN_DOWN && SIZE > SIZE_W'(SIZE_MIN))
                        size_d = SIZE - 1'b1;
                end else if (adjust) begin
                    if (BTN_UP && COLOR_NUM < COLOR_W'(COLOR_MAX))
                        color_d = COLOR_NUM + 1'b1;
                    else if (BTN_DOWN && COLOR_NUM > COLOR_W'(COLOR_MIN))
                        color_d = COLOR_NUM - 1'b1;
                end
            end

            PLAY: begin
                if (BTN_START) begin
                    state_d = SET_SIZE;
                    mode_d  = 1'b0;
                    sorc_d  = 1'b1;
                end else begin
                    if (MOVE_VALID)
                        tries_d = tries_inc;
                    if (hold_q != 2'd0)
                        hold_d = hold_q - 1'b1;
                    // A done board outranks a spent budget on the same edge.
                    if (BOARD_DONE && hold_q == 2'd0) begin
                        state_d = WON;
                        win_d   = 1'b1;
                    end else if (MOVE_VALID && tries_inc == TOTAL_TRIES) begin
                        state_d = LOST;
                        lose_d  = 1'b1;
                    end
                end
            end

            WON, LOST: begin
                if (BTN_START) begin
                    state_d = SET_SIZE;
                    mode_d  = 1'b0;
                    sorc_d  = 1'b1;
                    win_d   = 1'b0;
                    lose_d  = 1'b0;
                end
            end

            default: state_d = SET_SIZE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= SET_SIZE;
            SIZE        <= SIZE_W'(SIZE_DEFAULT);
            COLOR_NUM   <= COLOR_W'(COLOR_DEFAULT);
            sORc        <= 1'b1;
            MODE        <= 1'b0;
            TRIES       <= '0;
            TOTAL_TRIES <= '0;
            GAME_START  <= 1'b0;
            WIN         <= 1'b0;
            LOSE        <= 1'b0;
            hold_q      <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q     <= state_d;
            SIZE        <= size_d;
            COLOR_NUM   <= color_d;
            sORc        <= sorc_d;
            MODE        <= mode_d;
            TRIES       <= tries_d;
            TOTAL_TRIES <= total_d;
            GAME_START  <= game_start_d;
            WIN         <= win_d;
            LOSE        <= lose_d;
            hold_q      <= hold_d;
        end
    end

endmodule

// File: tb/tb_flood_game_ctrl.sv
// Directed bench for flood_game_ctrl plus an exhaustive sweep of flood_try_budget.
// Inputs change on the falling edge; outputs are checked 1 time unit after the rising edge.
module tb_flood_game_ctrl;
    import flood_pkg::*;

    logic               CLOCK = 1'b0;
    logic               RESET_N;
    logic               BTN_UP, BTN_DOWN, BTN_SEL, BTN_START, MOVE_VALID, BOARD_DONE;
    logic [SIZE_W-1:0]  SIZE;
    logic [COLOR_W-1:0] COLOR_NUM;
    logic               sORc, MODE, GAME_START, WIN, LOSE;
    logic [TRY_W-1:0]   TRIES, TOTAL_TRIES;

    logic [SIZE_W-1:0]  b_size;
    logic [COLOR_W-1:0] b_color;
    logic [TRY_W-1:0]   b_budget;

    int checks = 0;
    int errors = 0;

    always #5 CLOCK = ~CLOCK;

    flood_game_ctrl dut (
        .CLOCK       (CLOCK),
        .RESET_N     (RESET_N),
        .BTN_UP      (BTN_UP),
        .BTN_DOWN    (BTN_DOWN),
        .BTN_SEL     (BTN_SEL),
        .BTN_START   (BTN_START),
        .MOVE_VALID  (MOVE_VALID),
        .BOARD_DONE  (BOARD_DONE),
        .SIZE        (SIZE),
        .COLOR_NUM   (COLOR_NUM),
        .sORc        (sORc),
        .MODE        (MODE),
        .TRIES       (TRIES),
        .TOTAL_TRIES (TOTAL_TRIES),
        .GAME_START  (GAME_START),
        .WIN         (WIN),
        .LOSE        (LOSE)
    );

    flood_try_budget u_budget (
        .SIZE        (b_size),
        .COLOR_NUM   (b_color),
        .TOTAL_TRIES (b_budget)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step(input logic up, input logic down, input logic sel,
                        input logic start, input logic mv, input logic done);
        @(negedge CLOCK);
        BTN_UP = up; BTN_DOWN = down; BTN_SEL = sel;
        BTN_START = start; MOVE_VALID = mv; BOARD_DONE = done;
        @(posedge CLOCK);
        #1;
        BTN_UP = 0; BTN_DOWN = 0; BTN_SEL = 0;
        BTN_START = 0; MOVE_VALID = 0; BOARD_DONE = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " SIZE"}, 32'(SIZE), 6);
        check({tag, " COLOR_NUM"}, 32'(COLOR_NUM), 4);
        check({tag, " sORc"}, 32'(sORc), 1);
        check({tag, " MODE"}, 32'(MODE), 0);
        check({tag, " TRIES"}, 32'(TRIES), 0);
        check({tag, " TOTAL_TRIES"}, 32'(TOTAL_TRIES), 0);
        check({tag, " GAME_START"}, 32'(GAME_START), 0);
        check({tag, " WIN"}, 32'(WIN), 0);
        check({tag, " LOSE"}, 32'(LOSE), 0);
    endtask

    initial begin
        int model;
        RESET_N = 0;
        BTN_UP = 0; BTN_DOWN = 0; BTN_SEL = 0;
        BTN_START = 0; MOVE_VALID = 0; BOARD_DONE = 0;
        b_size = '0; b_color = '0;

        #12;
        check_reset_values("reset");
        @(negedge CLOCK);
        RESET_N = 1;
        step(0, 0, 0, 0, 0, 0);
        check_reset_values("post_reset idle");

        // Size saturates at 14 after eight of the ten presses.
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 0);
        check("size_sat_max", 32'(SIZE), 14);

        step(0, 0, 1, 0, 0, 0);
        check("sel_to_color sORc", 32'(sORc), 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0);
        check("color_sat_min", 32'(COLOR_NUM), 3);
        check("color_sat_min size kept", 32'(SIZE), 14);
        step(1, 0, 0, 0, 0, 0);
        check("color_up", 32'(COLOR_NUM), 4);
        step(1, 1, 0, 0, 0, 0);
        check("up_down_together", 32'(COLOR_NUM), 4);

        step(0, 0, 1, 0, 0, 0);
        check("sel_to_size sORc", 32'(sORc), 1);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, 0);
        check("size_back_to_6", 32'(SIZE), 6);

        // Game 1: budget 18, win after 17 moves.
        step(0, 0, 0, 1, 0, 0);
        check("start MODE", 32'(MODE), 1);
        check("start TOTAL_TRIES", 32'(TOTAL_TRIES), 18);
        check("start TRIES", 32'(TRIES), 0);
        check("start GAME_START", 32'(GAME_START), 1);
        check("start sORc held", 32'(sORc), 1);
        step(1, 0, 1, 0, 0, 0);
        check("game_start one cycle", 32'(GAME_START), 0);
        check("play ignores UP", 32'(SIZE), 6);
        check("play ignores SEL", 32'(sORc), 1);
        for (int i = 0; i < 17; i++) step(0, 0, 0, 0, 1, 0);
        check("g1 tries17", 32'(TRIES), 17);
        check("g1 no lose yet", 32'(LOSE), 0);
        step(0, 0, 0, 0, 0, 1);
        check("g1 WIN", 32'(WIN), 1);
        check("g1 LOSE", 32'(LOSE), 0);
        check("g1 TRIES frozen", 32'(TRIES), 17);
        step(0, 0, 0, 0, 1, 0);
        check("won ignores move", 32'(TRIES), 17);
        check("won MODE", 32'(MODE), 1);

        step(0, 0, 0, 1, 0, 0);
        check("won->setup MODE", 32'(MODE), 0);
        check("won->setup WIN", 32'(WIN), 0);
        check("won->setup sORc", 32'(sORc), 1);
        check("won->setup SIZE", 32'(SIZE), 6);
        check("won->setup COLOR", 32'(COLOR_NUM), 4);
        check("won->setup GAME_START", 32'(GAME_START), 0);

        // Game 2: budget exhausted on the 18th move.
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 17; i++) step(0, 0, 0, 0, 1, 0);
        check("g2 tries17 LOSE", 32'(LOSE), 0);
        step(0, 0, 0, 0, 1, 0);
        check("g2 LOSE", 32'(LOSE), 1);
        check("g2 WIN", 32'(WIN), 0);
        check("g2 TRIES", 32'(TRIES), 18);
        step(0, 0, 0, 1, 0, 0);
        check("lost->setup LOSE", 32'(LOSE), 0);
        check("lost->setup MODE", 32'(MODE), 0);

        // Game 3: final budgeted move together with done wins.
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 17; i++) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1);
        check("g3 WIN", 32'(WIN), 1);
        check("g3 LOSE", 32'(LOSE), 0);
        check("g3 TRIES", 32'(TRIES), 18);
        step(0, 0, 0, 1, 0, 0);

        // Stale done ignored for the start-pulse cycle and the one after.
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        check("stale done cycle0", 32'(WIN), 0);
        step(0, 0, 0, 0, 0, 1);
        check("stale done cycle1", 32'(WIN), 0);
        step(0, 0, 0, 0, 0, 1);
        check("done honoured", 32'(WIN), 1);
        step(0, 0, 0, 1, 0, 0);

        // Largest board, most colours; reset mid-game.
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("color_sat_max", 32'(COLOR_NUM), 6);
        step(1, 0, 0, 0, 0, 0);
        check("color_sat_max hold", 32'(COLOR_NUM), 6);
        step(0, 0, 0, 1, 0, 0);
        check("big TOTAL_TRIES", 32'(TOTAL_TRIES), 56);
        check("big start sORc held", 32'(sORc), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
        check("big TRIES", 32'(TRIES), 3);
        #2;
        RESET_N = 0;
        #1;
        check_reset_values("async reset");
        @(negedge CLOCK);
        RESET_N = 1;

        // START outranks SEL in setup.
        step(0, 0, 1, 1, 0, 0);
        check("start_over_sel MODE", 32'(MODE), 1);
        check("start_over_sel GAME_START", 32'(GAME_START), 1);
        check("start_over_sel sORc", 32'(sORc), 1);
        check("start_over_sel TOTAL", 32'(TOTAL_TRIES), 18);

        // Exhaustive budget sweep against an independent integer model.
        for (int s = 0; s < 32; s++) begin
            for (int c = 0; c < 16; c++) begin
                b_size  = SIZE_W'(s);
                b_color = COLOR_W'(c);
                #1;
                model = s + (s * c) / 2;
                if (model > 99) model = 99;
                check($sformatf("budget s=%0d c=%0d", s, c), 32'(b_budget), 32'(model));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
